// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   memState_t      : access sequencer states (IDLE, REQ, DONE)
//   *_DEF           : default widths and timeout used by mem_stage
//   toCntW()        : width of the REQ-cycle timeout counter
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memState_t;

    localparam int DATA_W_DEF      = 32;
    localparam int REG_ADR_W_DEF   = 5;
    localparam int TIMEOUT_CYC_DEF = 255;

    // The counter only has to hold 0 .. timeoutCyc-1; keep at least one bit.
    function automatic int toCntW(input int timeoutCyc);
        return (timeoutCyc < 2) ? 1 : $clog2(timeoutCyc);
    endfunction

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register.
//   clk, rst          : clock, synchronous active-high reset (clears every field)
//   load              : capture all inputs (memData only when loadMemData=1)
//   bubble            : clear regWrite/memtoReg, every other field holds
//   loadMemData       : qualifies memData capture on a load
//   memData..regWrite : incoming fields
//   out*              : registered fields feeding write-back
module mem_wb_reg #(
    parameter int DATA_W    = 32,
    parameter int REG_ADR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 bubble,
    input  logic                 loadMemData,
    input  logic [DATA_W-1:0]    memData,
    input  logic [DATA_W-1:0]    aluResult,
    input  logic [REG_ADR_W-1:0] regWriteAdr,
    input  logic                 memtoReg,
    input  logic                 regWrite,
    output logic [DATA_W-1:0]    outMemData,
    output logic [DATA_W-1:0]    outALUResult,
    output logic [REG_ADR_W-1:0] outRegWriteAdr,
    output logic                 outMemtoReg,
    output logic                 outRegWrite
);

    always_ff @(posedge clk) begin
        if (rst) begin
            outMemData     <= '0;
            outALUResult   <= '0;
            outRegWriteAdr <= '0;
            outMemtoReg    <= 1'b0;
            outRegWrite    <= 1'b0;
        end else if (bubble) begin
            outMemtoReg <= 1'b0;
            outRegWrite <= 1'b0;
        end else if (load) begin
            outALUResult   <= aluResult;
            outRegWriteAdr <= regWriteAdr;
            outMemtoReg    <= memtoReg;
            outRegWrite    <= regWrite;
            if (loadMemData) begin
                outMemData <= memData;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives a req/ack data-memory bus for loads and stores,
// stalls upstream while an access is outstanding, and owns the MEM/WB register.
//   clk, rst          : clock, synchronous active-high reset
//   MEM_In*           : instruction fields from the EX/MEM register
//   dmem_req/we/addr/wdata : registered bus request, stable while dmem_req=1
//   dmem_ack/rdata    : one-cycle completion strobe and read data
//   MEM_Stall         : combinational hold for PC, IF/ID, ID/EX, EX/MEM
//   MEM_BusErr        : sticky flag, set when a request times out
//   MEM_Misalign      : one-cycle pulse on a dropped misaligned access
//   MEMWB_Out*        : MEM/WB register outputs
// Optional feature: define MEM_MISALIGN_CHECK_EN to drop accesses whose address
// is not word aligned (no request, no stall, bubble plus MEM_Misalign pulse).
// Without it MEM_Misalign is tied 0 and every access goes to the bus.
import mem_stage_pkg::*;

module mem_stage #(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REG_ADR_W   = REG_ADR_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    MEM_InALUResult,
    input  logic [DATA_W-1:0]    MEM_InRtData,
    input  logic [REG_ADR_W-1:0] MEM_InRegWriteAdr,
    input  logic                 MEM_InMemWrite,
    input  logic                 MEM_InMemRead,
    input  logic                 MEM_InMemtoReg,
    input  logic                 MEM_InRegWrite,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DATA_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 MEM_Stall,
    output logic                 MEM_BusErr,
    output logic                 MEM_Misalign,
    output logic [DATA_W-1:0]    MEMWB_OutMemData,
    output logic [DATA_W-1:0]    MEMWB_OutALUResult,
    output logic [REG_ADR_W-1:0] MEMWB_OutRegWriteAdr,
    output logic                 MEMWB_OutMemtoReg,
    output logic                 MEMWB_OutRegWrite
);

    localparam int CNT_W = toCntW(TIMEOUT_CYC);

    memState_t         state;
    logic [CNT_W-1:0]  reqCnt;
    logic [DATA_W-1:0] capData;
    logic              access;
    logic              misaligned;
    logic              startAcc;
    logic              timeout;
    logic              wbLoad;
    logic              wbBubble;
    logic              wbLoadMem;

    // A read+write combination is issued as a write (dmem_we from MemWrite).
    assign access = MEM_InMemRead | MEM_InMemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = access && (MEM_InALUResult[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign startAcc  = (state == IDLE) && access && !misaligned;
    // reqCnt holds the number of REQ cycles already spent without an ack.
    assign timeout   = (reqCnt == CNT_W'(TIMEOUT_CYC - 1));
    assign MEM_Stall = startAcc || (state == REQ);

    // MEM/WB control: bubble while an access is in flight (or dropped),
    // load the instruction on its completing edge.
    always_comb begin
        wbLoad    = 1'b0;
        wbBubble  = 1'b0;
        wbLoadMem = 1'b0;
        case (state)
            IDLE: begin
                if (access) wbBubble = 1'b1;
                else        wbLoad   = 1'b1;
            end
            REQ:  wbBubble = 1'b1;
            DONE: begin
                wbLoad    = 1'b1;
                wbLoadMem = ~dmem_we;
            end
            default: ;
        endcase
    end

    // ---- access sequencer / bus registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            reqCnt     <= '0;
            capData    <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            MEM_BusErr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startAcc) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MEM_InMemWrite;
                        dmem_addr  <= MEM_InALUResult;
                        dmem_wdata <= MEM_InRtData;
                        reqCnt     <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // ack takes priority over a timeout on the same cycle
                    if (dmem_ack) begin
                        if (!dmem_we) capData <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end else if (timeout) begin
                        capData    <= '0;
                        dmem_req   <= 1'b0;
                        MEM_BusErr <= 1'b1;
                        state      <= DONE;
                    end else begin
                        reqCnt <= reqCnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalignQ;

    always_ff @(posedge clk) begin
        if (rst) misalignQ <= 1'b0;
        else     misalignQ <= (state == IDLE) && misaligned;
    end

    assign MEM_Misalign = misalignQ;
`else
    assign MEM_Misalign = 1'b0;
`endif

    // ---- MEM/WB boundary ----
    mem_wb_reg #(
        .DATA_W    (DATA_W),
        .REG_ADR_W (REG_ADR_W)
    ) uMemWb (
        .clk            (clk),
        .rst            (rst),
        .load           (wbLoad),
        .bubble         (wbBubble),
        .loadMemData    (wbLoadMem),
        .memData        (capData),
        .aluResult      (MEM_InALUResult),
        .regWriteAdr    (MEM_InRegWriteAdr),
        .memtoReg       (MEM_InMemtoReg),
        .regWrite       (MEM_InRegWrite),
        .outMemData     (MEMWB_OutMemData),
        .outALUResult   (MEMWB_OutALUResult),
        .outRegWriteAdr (MEMWB_OutRegWriteAdr),
        .outMemtoReg    (MEMWB_OutMemtoReg),
        .outRegWrite    (MEMWB_OutRegWrite)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver plays the upstream pipeline,
// a responder plays the data memory, and a monitor checks every retired
// instruction against expectations pushed at issue time.
module tb_mem_stage;

    localparam int DATA_W      = 32;
    localparam int REG_ADR_W   = 5;
    localparam int TIMEOUT_CYC = 4;
    localparam int NO_ACK      = TIMEOUT_CYC + 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DATA_W-1:0]    MEM_InALUResult;
    logic [DATA_W-1:0]    MEM_InRtData;
    logic [REG_ADR_W-1:0] MEM_InRegWriteAdr;
    logic                 MEM_InMemWrite;
    logic                 MEM_InMemRead;
    logic                 MEM_InMemtoReg;
    logic                 MEM_InRegWrite;
    logic                 dmem_req;
    logic                 dmem_we;
    logic [DATA_W-1:0]    dmem_addr;
    logic [DATA_W-1:0]    dmem_wdata;
    logic                 dmem_ack = 1'b0;
    logic [DATA_W-1:0]    dmem_rdata = '0;
    logic                 MEM_Stall;
    logic                 MEM_BusErr;
    logic                 MEM_Misalign;
    logic [DATA_W-1:0]    MEMWB_OutMemData;
    logic [DATA_W-1:0]    MEMWB_OutALUResult;
    logic [REG_ADR_W-1:0] MEMWB_OutRegWriteAdr;
    logic                 MEMWB_OutMemtoReg;
    logic                 MEMWB_OutRegWrite;

    mem_stage #(
        .DATA_W      (DATA_W),
        .REG_ADR_W   (REG_ADR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .MEM_InALUResult      (MEM_InALUResult),
        .MEM_InRtData         (MEM_InRtData),
        .MEM_InRegWriteAdr    (MEM_InRegWriteAdr),
        .MEM_InMemWrite       (MEM_InMemWrite),
        .MEM_InMemRead        (MEM_InMemRead),
        .MEM_InMemtoReg       (MEM_InMemtoReg),
        .MEM_InRegWrite       (MEM_InRegWrite),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_ack             (dmem_ack),
        .dmem_rdata           (dmem_rdata),
        .MEM_Stall            (MEM_Stall),
        .MEM_BusErr           (MEM_BusErr),
        .MEM_Misalign         (MEM_Misalign),
        .MEMWB_OutMemData     (MEMWB_OutMemData),
        .MEMWB_OutALUResult   (MEMWB_OutALUResult),
        .MEMWB_OutRegWriteAdr (MEMWB_OutRegWriteAdr),
        .MEMWB_OutMemtoReg    (MEMWB_OutMemtoReg),
        .MEMWB_OutRegWrite    (MEMWB_OutRegWrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  adr;
        logic        m2r;
        logic        rw;
        logic [31:0] memData;
        logic        busErr;
        logic        misal;
        int          stallCyc;
    } wbExp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        we;
        int          lat;
        int          reqCyc;
    } busExp_t;

    wbExp_t  wbQ[$];
    busExp_t busQ[$];

    int nChecks = 0;
    int nPass   = 0;
    bit scbOn     = 1'b0;
    bit instValid = 1'b0;
    bit forceAck  = 1'b0;

    // reference model state: what MEM/WB should currently hold
    logic [31:0] mLastMem = '0;
    logic [31:0] mLastAlu = '0;
    logic [4:0]  mLastAdr = '0;
    logic        mBusErr  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Issue one instruction from EX/MEM and hold it until the stage accepts it.
    // lat = REQ cycle on which memory acks; lat > TIMEOUT_CYC means never.
    task automatic issue(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] adr,
                         input logic rd, input logic wr, input logic m2r, input logic rw,
                         input int lat, input logic [31:0] rdata);
        wbExp_t  e;
        busExp_t b;
        bit acc, mis, to, s;
        int n;
        acc = rd | wr;
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = acc && (alu[1:0] != 2'b00);
`endif
        to = (lat > TIMEOUT_CYC);
        e.misal = mis;
        if (mis) begin
            e.alu = mLastAlu; e.adr = mLastAdr; e.m2r = 1'b0; e.rw = 1'b0;
            e.memData = mLastMem; e.stallCyc = 0;
        end else begin
            e.alu = alu; e.adr = adr; e.m2r = m2r; e.rw = rw;
            if (acc && !wr) mLastMem = to ? 32'h0 : rdata;
            e.memData  = mLastMem;
            e.stallCyc = acc ? 1 + (to ? TIMEOUT_CYC : lat) : 0;
            if (acc) begin
                mBusErr  = mBusErr | to;
                b.addr   = alu;
                b.wdata  = rt;
                b.rdata  = rdata;
                b.we     = wr;
                b.lat    = lat;
                b.reqCyc = to ? TIMEOUT_CYC : lat;
                busQ.push_back(b);
            end
            mLastAlu = alu;
            mLastAdr = adr;
        end
        e.busErr = mBusErr;
        wbQ.push_back(e);

        MEM_InALUResult   = alu;
        MEM_InRtData      = rt;
        MEM_InRegWriteAdr = adr;
        MEM_InMemRead     = rd;
        MEM_InMemWrite    = wr;
        MEM_InMemtoReg    = m2r;
        MEM_InRegWrite    = rw;
        instValid         = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            s = MEM_Stall;
            @(posedge clk);
            #1;
            if (!s) break;
            n++;
            if (n > 40) begin
                chk("issue_stall_bound", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic randInstr(input bit allowTimeout);
        int kind, lat;
        logic [31:0] alu;
        kind = $urandom_range(0, 3);
        alu  = $urandom;
        if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
        lat = $urandom_range(1, TIMEOUT_CYC);
        if (allowTimeout && $urandom_range(0, 5) == 0) lat = NO_ACK;
        issue(alu, $urandom, 5'($urandom), (kind == 1 || kind == 3), (kind == 2 || kind == 3),
              1'($urandom), 1'($urandom), lat, $urandom);
    endtask

    // monitor: compare MEM/WB after each retiring edge, check bubbles while stalled
    bit pend = 1'b0;
    bit prevStall = 1'b0;
    int stallCnt = 0;
    always @(negedge clk) begin : monitor
        wbExp_t e;
        if (scbOn) begin
            if (pend) begin
                if (wbQ.size() == 0) begin
                    chk("wb_unexpected_retire", 64'd1, 64'd0);
                end else begin
                    e = wbQ.pop_front();
                    chk("wb_alu",      MEMWB_OutALUResult,   e.alu);
                    chk("wb_adr",      MEMWB_OutRegWriteAdr, e.adr);
                    chk("wb_memtoreg", MEMWB_OutMemtoReg,    e.m2r);
                    chk("wb_regwrite", MEMWB_OutRegWrite,    e.rw);
                    chk("wb_memdata",  MEMWB_OutMemData,     e.memData);
                    chk("bus_err",     MEM_BusErr,           e.busErr);
                    chk("misalign",    MEM_Misalign,         e.misal);
                    chk("stall_cycles", 64'(stallCnt),       64'(e.stallCyc));
                end
                stallCnt = 0;
            end
            if (prevStall) begin
                chk("bubble_regwrite", MEMWB_OutRegWrite, 64'd0);
                chk("bubble_memtoreg", MEMWB_OutMemtoReg, 64'd0);
            end
            pend      = instValid && !MEM_Stall;
            prevStall = instValid && MEM_Stall;
            if (prevStall) stallCnt++;
        end else begin
            pend      = 1'b0;
            prevStall = 1'b0;
            stallCnt  = 0;
        end
    end

    // memory responder: checks each request and acks on the chosen REQ cycle
    int reqCnt = 0;
    busExp_t cur;
    always @(negedge clk) begin : responder
        if (!scbOn) begin
            dmem_ack   = forceAck;
            dmem_rdata = 32'h5A5A_5A5A;
            reqCnt     = 0;
        end else if (dmem_req) begin
            if (reqCnt == 0) begin
                if (busQ.size() == 0) begin
                    chk("bus_unexpected_req", 64'd1, 64'd0);
                    cur.addr = dmem_addr; cur.we = dmem_we; cur.wdata = dmem_wdata;
                    cur.rdata = '0; cur.lat = 1; cur.reqCyc = 1;
                end else begin
                    cur = busQ.pop_front();
                    chk("bus_addr",  dmem_addr,  cur.addr);
                    chk("bus_we",    dmem_we,    cur.we);
                    chk("bus_wdata", dmem_wdata, cur.wdata);
                end
            end else begin
                chk("bus_addr_stable",  dmem_addr,  cur.addr);
                chk("bus_we_stable",    dmem_we,    cur.we);
                chk("bus_wdata_stable", dmem_wdata, cur.wdata);
            end
            reqCnt++;
            dmem_ack   = (reqCnt == cur.lat);
            dmem_rdata = (reqCnt == cur.lat) ? cur.rdata : $urandom;
        end else begin
            if (reqCnt != 0) begin
                chk("bus_req_cycles", 64'(reqCnt), 64'(cur.reqCyc));
                reqCnt = 0;
            end
            // stray acks while no request is pending must be ignored
            dmem_ack   = ($urandom_range(0, 7) == 0);
            dmem_rdata = $urandom;
        end
    end

    task automatic clearInputs();
        MEM_InALUResult   = '0;
        MEM_InRtData      = '0;
        MEM_InRegWriteAdr = '0;
        MEM_InMemRead     = 1'b0;
        MEM_InMemWrite    = 1'b0;
        MEM_InMemtoReg    = 1'b0;
        MEM_InRegWrite    = 1'b0;
        instValid         = 1'b0;
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_req"},      dmem_req,             64'd0);
        chk({tag, "_we"},       dmem_we,              64'd0);
        chk({tag, "_addr"},     dmem_addr,            64'd0);
        chk({tag, "_wdata"},    dmem_wdata,           64'd0);
        chk({tag, "_stall"},    MEM_Stall,            64'd0);
        chk({tag, "_buserr"},   MEM_BusErr,           64'd0);
        chk({tag, "_misalign"}, MEM_Misalign,         64'd0);
        chk({tag, "_memdata"},  MEMWB_OutMemData,     64'd0);
        chk({tag, "_alu"},      MEMWB_OutALUResult,   64'd0);
        chk({tag, "_adr"},      MEMWB_OutRegWriteAdr, 64'd0);
        chk({tag, "_memtoreg"}, MEMWB_OutMemtoReg,    64'd0);
        chk({tag, "_regwrite"}, MEMWB_OutRegWrite,    64'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        rst = 1'b1;
        clearInputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chkAllZero("reset");
        @(posedge clk);
        #1;
        rst   = 1'b0;
        scbOn = 1'b1;

        // directed: ALU pass-through, load with 3-cycle wait, store with immediate ack
        issue(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
        issue(32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
        issue(32'h0000_0080, 32'h0000_CAFE, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 32'h0);
        for (int i = 0; i < 60; i++) randInstr(1'b0);
        // directed: load that is never acknowledged
        issue(32'h0000_0044, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, NO_ACK, 32'h1111_1111);
        for (int i = 0; i < 120; i++) randInstr(1'b1);

        clearInputs();
        repeat (3) @(negedge clk);
        chk("wb_queue_drained",  64'(wbQ.size()),  64'd0);
        chk("bus_queue_drained", 64'(busQ.size()), 64'd0);
        chk("buserr_sticky", MEM_BusErr, 64'(mBusErr));
        scbOn = 1'b0;

        // reset in the middle of an access, then a late ack
        @(posedge clk);
        #1;
        forceAck          = 1'b0;
        MEM_InALUResult   = 32'h0000_0100;
        MEM_InMemRead     = 1'b1;
        MEM_InMemtoReg    = 1'b1;
        MEM_InRegWrite    = 1'b1;
        MEM_InRegWriteAdr = 5'd3;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_mid_req_active", dmem_req, 64'd1);
        rst = 1'b1;
        clearInputs();
        @(posedge clk);
        #1;
        chkAllZero("rst_mid");
        rst      = 1'b0;
        forceAck = 1'b1;
        @(posedge clk);
        #1;
        forceAck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkAllZero("late_ack");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
